// File: rtl/matrix_operand_sequencer.sv
`default_nettype none
// matrix_operand_sequencer: walks C = A*B in row-major order and fetches A[i][k]/B[k][j]
// pairs, dispatching them in order to NUM_LANES multiplier lanes with boundary tags. Rev 1.0
module matrix_operand_sequencer #(
    parameter int A_ROWS     = 8,
    parameter int INNER      = 8,
    parameter int B_COLS     = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 4,
    localparam int AAW = (A_ROWS * INNER > 1) ? $clog2(A_ROWS * INNER) : 1,
    localparam int BAW = (INNER * B_COLS > 1) ? $clog2(INNER * B_COLS) : 1,
    localparam int RW  = (A_ROWS > 1) ? $clog2(A_ROWS) : 1,
    localparam int CW  = (B_COLS > 1) ? $clog2(B_COLS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              rd_en_a,
    output logic                              rd_en_b,
    output logic [AAW-1:0]                    rd_addr_a,
    output logic [BAW-1:0]                    rd_addr_b,
    input  logic [DATA_WIDTH-1:0]             rd_data_a,
    input  logic [DATA_WIDTH-1:0]             rd_data_b,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   lane_a,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   lane_b,
    output logic [NUM_LANES-1:0]              lane_en,
    input  logic [NUM_LANES-1:0]              lane_busy,
    output logic                              tag_first,
    output logic                              tag_last,
    output logic [RW-1:0]                     tag_row,
    output logic [CW-1:0]                     tag_col,
    output logic                              new_row
);

    localparam int KW = (INNER > 1) ? $clog2(INNER) : 1;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [RW-1:0]  i_q;
    logic [CW-1:0]  j_q;
    logic [KW-1:0]  k_q;
    logic [LW-1:0]  lane_q;
    logic [AAW-1:0] addr_a_q;
    logic [AAW-1:0] row_base_q;
    logic [BAW-1:0] addr_b_q;

    logic           s1_v_q;
    logic [LW-1:0]  s1_lane_q;
    logic           s1_first_q;
    logic           s1_last_q;
    logic           s1_nrow_q;
    logic [RW-1:0]  s1_row_q;
    logic [CW-1:0]  s1_col_q;

    logic [NUM_LANES-1:0]            lane_en_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_a_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_b_q;
    logic                            tag_first_q;
    logic                            tag_last_q;
    logic                            new_row_q;
    logic [RW-1:0]                   tag_row_q;
    logic [CW-1:0]                   tag_col_q;

    logic [NUM_LANES-1:0] w_tgt_oh;
    logic [NUM_LANES-1:0] w_s1_oh;
    logic                 w_free;
    logic                 w_issue;
    logic                 w_k_last;
    logic                 w_j_last;
    logic                 w_i_last;

    // A lane is occupied from issue through its lane_en cycle (stage 1 and output stage).
    always_comb begin
        w_tgt_oh = '0;
        w_s1_oh  = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            w_tgt_oh[n] = (lane_q == LW'(n));
            w_s1_oh[n]  = s1_v_q && (s1_lane_q == LW'(n));
        end
    end

    assign w_free   = ((lane_busy | w_s1_oh | lane_en_q) & w_tgt_oh) == '0;
    assign w_issue  = (state_q == S_FETCH) && w_free;
    assign w_k_last = (k_q == KW'(INNER - 1));
    assign w_j_last = (j_q == CW'(B_COLS - 1));
    assign w_i_last = (i_q == RW'(A_ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_issue && w_k_last && w_j_last && w_i_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!s1_v_q && (lane_en_q == '0)) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses are stepped incrementally; row_base_q remembers i*K for reuse across columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            lane_q     <= '0;
            addr_a_q   <= '0;
            row_base_q <= '0;
            addr_b_q   <= '0;
        end else if (w_issue) begin
            if (w_k_last) begin
                k_q    <= '0;
                lane_q <= '0;
                if (w_j_last) begin
                    j_q      <= '0;
                    addr_b_q <= '0;
                    if (w_i_last) begin
                        i_q        <= '0;
                        addr_a_q   <= '0;
                        row_base_q <= '0;
                    end else begin
                        i_q        <= i_q + RW'(1);
                        addr_a_q   <= addr_a_q + AAW'(1);
                        row_base_q <= addr_a_q + AAW'(1);
                    end
                end else begin
                    j_q      <= j_q + CW'(1);
                    addr_a_q <= row_base_q;
                    addr_b_q <= BAW'(j_q) + BAW'(1);
                end
            end else begin
                k_q      <= k_q + KW'(1);
                lane_q   <= (lane_q == LW'(NUM_LANES - 1)) ? '0 : lane_q + LW'(1);
                addr_a_q <= addr_a_q + AAW'(1);
                addr_b_q <= addr_b_q + BAW'(B_COLS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_lane_q   <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_nrow_q   <= 1'b0;
            s1_row_q    <= '0;
            s1_col_q    <= '0;
            lane_en_q   <= '0;
            lane_a_q    <= '0;
            lane_b_q    <= '0;
            tag_first_q <= 1'b0;
            tag_last_q  <= 1'b0;
            new_row_q   <= 1'b0;
            tag_row_q   <= '0;
            tag_col_q   <= '0;
        end else begin
            s1_v_q <= w_issue;
            if (w_issue) begin
                s1_lane_q  <= lane_q;
                s1_first_q <= (k_q == '0);
                s1_last_q  <= w_k_last;
                s1_nrow_q  <= w_k_last && w_j_last;
                s1_row_q   <= i_q;
                s1_col_q   <= j_q;
            end
            lane_en_q   <= w_s1_oh;
            tag_first_q <= s1_v_q && s1_first_q;
            tag_last_q  <= s1_v_q && s1_last_q;
            new_row_q   <= s1_v_q && s1_nrow_q;
            if (s1_v_q) begin
                tag_row_q <= s1_row_q;
                tag_col_q <= s1_col_q;
            end
            for (int n = 0; n < NUM_LANES; n++) begin
                if (w_s1_oh[n]) begin
                    lane_a_q[n*DATA_WIDTH +: DATA_WIDTH] <= rd_data_a;
                    lane_b_q[n*DATA_WIDTH +: DATA_WIDTH] <= rd_data_b;
                end
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign rd_en_a   = w_issue;
    assign rd_en_b   = w_issue;
    assign rd_addr_a = addr_a_q;
    assign rd_addr_b = addr_b_q;
    assign lane_a    = lane_a_q;
    assign lane_b    = lane_b_q;
    assign lane_en   = lane_en_q;
    assign tag_first = tag_first_q;
    assign tag_last  = tag_last_q;
    assign tag_row   = tag_row_q;
    assign tag_col   = tag_col_q;
    assign new_row   = new_row_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_operand_sequencer.sv
`default_nettype none
// tb_matrix_operand_sequencer: directed checks of three sequencer configurations
// (2x3x2 on 4 lanes, single lane K=4, K=1 on 4 lanes) against hand-derived values.
module tb_matrix_operand_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instance A: M=2, K=3, N=2, L=4, W=8
    logic        a_start = 1'b0;
    logic [3:0]  a_lbusy = 4'b0;
    logic        a_busy, a_done, a_rea, a_reb, a_tf, a_tl, a_nr, a_tr, a_tc;
    logic [2:0]  a_aa, a_ab;
    logic [7:0]  a_rda, a_rdb;
    logic [31:0] a_la, a_lb;
    logic [3:0]  a_en;

    matrix_operand_sequencer #(.A_ROWS(2), .INNER(3), .B_COLS(2), .DATA_WIDTH(8), .NUM_LANES(4)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .rd_en_a(a_rea), .rd_en_b(a_reb), .rd_addr_a(a_aa), .rd_addr_b(a_ab),
        .rd_data_a(a_rda), .rd_data_b(a_rdb), .lane_a(a_la), .lane_b(a_lb),
        .lane_en(a_en), .lane_busy(a_lbusy), .tag_first(a_tf), .tag_last(a_tl),
        .tag_row(a_tr), .tag_col(a_tc), .new_row(a_nr)
    );

    // Instance B: M=N=1, K=4, L=1
    logic        b_start = 1'b0;
    logic [0:0]  b_lbusy = 1'b0;
    logic        b_busy, b_done, b_rea, b_reb, b_tf, b_tl, b_nr, b_tr, b_tc;
    logic [1:0]  b_aa, b_ab;
    logic [7:0]  b_rda, b_rdb, b_la, b_lb;
    logic [0:0]  b_en;

    matrix_operand_sequencer #(.A_ROWS(1), .INNER(4), .B_COLS(1), .DATA_WIDTH(8), .NUM_LANES(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_en_a(b_rea), .rd_en_b(b_reb), .rd_addr_a(b_aa), .rd_addr_b(b_ab),
        .rd_data_a(b_rda), .rd_data_b(b_rdb), .lane_a(b_la), .lane_b(b_lb),
        .lane_en(b_en), .lane_busy(b_lbusy), .tag_first(b_tf), .tag_last(b_tl),
        .tag_row(b_tr), .tag_col(b_tc), .new_row(b_nr)
    );

    // Instance C: M=N=2, K=1, L=4
    logic        c_start = 1'b0;
    logic [3:0]  c_lbusy = 4'b0;
    logic        c_busy, c_done, c_rea, c_reb, c_tf, c_tl, c_nr, c_tr, c_tc;
    logic [0:0]  c_aa, c_ab;
    logic [7:0]  c_rda, c_rdb;
    logic [31:0] c_la, c_lb;
    logic [3:0]  c_en;

    matrix_operand_sequencer #(.A_ROWS(2), .INNER(1), .B_COLS(2), .DATA_WIDTH(8), .NUM_LANES(4)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
        .rd_en_a(c_rea), .rd_en_b(c_reb), .rd_addr_a(c_aa), .rd_addr_b(c_ab),
        .rd_data_a(c_rda), .rd_data_b(c_rdb), .lane_a(c_la), .lane_b(c_lb),
        .lane_en(c_en), .lane_busy(c_lbusy), .tag_first(c_tf), .tag_last(c_tl),
        .tag_row(c_tr), .tag_col(c_tc), .new_row(c_nr)
    );

    // Operand RAMs: one-cycle read latency, contents are address+1 (C's B RAM: address+17).
    always @(posedge clk) begin
        if (a_rea) a_rda <= 8'(a_aa) + 8'd1;
        if (a_reb) a_rdb <= 8'(a_ab) + 8'd1;
        if (b_rea) b_rda <= 8'(b_aa) + 8'd1;
        if (b_reb) b_rdb <= 8'(b_ab) + 8'd1;
        if (c_rea) c_rda <= 8'(c_aa) + 8'd1;
        if (c_reb) c_rdb <= 8'(c_ab) + 8'd17;
    end

    bit a_mon = 1'b0;
    int a_ni, a_np, a_gaps, a_en_total = 0, a_first_iss, a_first_en, a_last_en, a_done_cyc, a_busy_first, a_busy_last;
    int mi, mj, mk, pi, pj, pk;

    always @(negedge clk) begin
        if (a_en != 4'b0) a_en_total++;
        if (a_mon) begin
            if (a_rea) begin
                mk = a_ni % 3; mj = (a_ni / 3) % 2; mi = a_ni / 6;
                check("a_rd_en_b", a_reb, 1);
                check("a_addr_a", a_aa, mi * 3 + mk);
                check("a_addr_b", a_ab, mk * 2 + mj);
                if (a_ni == 0) a_first_iss = cyc;
                a_ni++;
            end else if (a_ni > 0 && a_ni < 12) begin
                a_gaps++;
            end
            if (a_en != 4'b0) begin
                pk = a_np % 3; pj = (a_np / 3) % 2; pi = a_np / 6;
                check("a_lane_en", a_en, 1 << pk);
                check("a_lane_a", a_la[pk*8 +: 8], pi * 3 + pk + 1);
                check("a_lane_b", a_lb[pk*8 +: 8], pk * 2 + pj + 1);
                check("a_tag_first", a_tf, pk == 0);
                check("a_tag_last", a_tl, pk == 2);
                check("a_tag_row", a_tr, pi);
                check("a_tag_col", a_tc, pj);
                check("a_new_row", a_nr, (pk == 2) && (pj == 1));
                if (a_np == 0) a_first_en = cyc;
                a_last_en = cyc;
                a_np++;
            end
            if (a_busy && a_busy_first < 0) a_busy_first = cyc;
            if (a_busy) a_busy_last = cyc;
            if (a_done) a_done_cyc = cyc;
        end
    end

    bit b_mon = 1'b0;
    int b_np = 0, b_prev = 0, b_done_cyc = -1;

    always @(negedge clk) begin
        if (b_mon) begin
            if (b_en != 1'b0) begin
                check("b_lane_en", b_en, 1);
                check("b_lane_a", b_la, b_np + 1);
                check("b_tag_first", b_tf, b_np == 0);
                check("b_tag_last", b_tl, b_np == 3);
                if (b_np > 0) check("b_interval", cyc - b_prev, 3);
                b_prev = cyc;
                b_np++;
            end
            if (b_done) b_done_cyc = cyc;
        end
    end

    bit c_mon = 1'b0;
    int c_ni = 0, c_np = 0, c_done_cnt = 0, c_done_cyc = -1, c_busy_last = -1;

    always @(negedge clk) begin
        if (c_mon) begin
            if (c_rea) begin
                check("c_addr_a", c_aa, c_ni / 2);
                check("c_addr_b", c_ab, c_ni % 2);
                c_ni++;
            end
            if (c_en != 4'b0) begin
                check("c_lane_en", c_en, 1);
                check("c_tag_first", c_tf, 1);
                check("c_tag_last", c_tl, 1);
                check("c_tag_row", c_tr, c_np / 2);
                check("c_tag_col", c_tc, c_np % 2);
                check("c_new_row", c_nr, (c_np % 2) == 1);
                check("c_lane_a", c_la[7:0], c_np / 2 + 1);
                check("c_lane_b", c_lb[7:0], c_np % 2 + 17);
                c_np++;
            end
            if (c_done) begin
                c_done_cnt++;
                c_done_cyc = cyc;
            end
            if (c_busy) c_busy_last = cyc;
        end
    end

    task automatic a_clear();
        a_ni = 0; a_np = 0; a_gaps = 0; a_first_iss = -1; a_first_en = -1;
        a_last_en = -1; a_done_cyc = -1; a_busy_first = -1; a_busy_last = -1;
    endtask

    task automatic a_wait_done();
        for (int t = 0; t < 60 && a_done_cyc < 0; t++) tick();
        tick();
        tick();
    endtask

    int c0;
    int snap;

    initial begin
        a_clear();
        repeat (3) tick();
        check("rst_ctrl", {a_busy, a_done, a_rea, a_reb, a_en, a_tf, a_tl, a_nr}, 0);
        check("rst_addr_tag", {a_aa, a_ab, a_tr, a_tc}, 0);
        check("rst_lanes", {a_la, a_lb}, 0);
        check("rst_other_busy", {b_busy, c_busy}, 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a job
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("rstmid_ctrl", {a_busy, a_done, a_rea, a_reb, a_en, a_tf, a_tl, a_nr}, 0);
        check("rstmid_addr_tag", {a_aa, a_ab, a_tr, a_tc}, 0);
        check("rstmid_lanes", {a_la, a_lb}, 0);
        snap = a_en_total;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("rstmid_no_lane_en", a_en_total - snap, 0);
        check("rstmid_idle", a_busy, 0);

        // Basic run, fresh start after reset
        a_clear();
        a_mon = 1'b1;
        a_start = 1'b1;
        c0 = cyc;
        tick();
        a_start = 1'b0;
        a_wait_done();
        check("basic_busy_first", a_busy_first, c0 + 1);
        check("basic_first_issue", a_first_iss, c0 + 1);
        check("basic_first_en", a_first_en, c0 + 3);
        check("basic_last_en", a_last_en, c0 + 14);
        check("basic_done", a_done_cyc, c0 + 15);
        check("basic_busy_last", a_busy_last, c0 + 15);
        check("basic_issues", a_ni, 12);
        check("basic_pairs", a_np, 12);
        check("basic_gaps", a_gaps, 0);

        // Backpressure: lane 1 busy for 5 cycles when the second pair is due
        a_clear();
        a_start = 1'b1;
        c0 = cyc;
        tick();
        a_start = 1'b0;
        tick();
        a_lbusy = 4'b0010;
        repeat (5) tick();
        a_lbusy = 4'b0000;
        a_wait_done();
        check("bp_first_issue", a_first_iss, c0 + 1);
        check("bp_gaps", a_gaps, 5);
        check("bp_issues", a_ni, 12);
        check("bp_pairs", a_np, 12);
        check("bp_last_en", a_last_en, c0 + 19);
        check("bp_done", a_done_cyc, c0 + 20);
        a_mon = 1'b0;

        // Single lane, K=4
        b_mon = 1'b1;
        b_start = 1'b1;
        c0 = cyc;
        tick();
        b_start = 1'b0;
        for (int t = 0; t < 60 && b_done_cyc < 0; t++) tick();
        tick();
        check("b_pairs", b_np, 4);
        check("b_last_en", b_prev, c0 + 12);
        check("b_done", b_done_cyc, c0 + 13);
        check("b_idle", b_busy, 0);
        b_mon = 1'b0;

        // K=1 with a start pulse while busy
        c_mon = 1'b1;
        c_start = 1'b1;
        c0 = cyc;
        tick();
        c_start = 1'b0;
        tick();
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        for (int t = 0; t < 60 && c_done_cyc < 0; t++) tick();
        repeat (10) tick();
        check("c_issues", c_ni, 4);
        check("c_pairs", c_np, 4);
        check("c_done_count", c_done_cnt, 1);
        check("c_done", c_done_cyc, c0 + 13);
        check("c_busy_last", c_busy_last, c0 + 13);
        c_mon = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/matrix_operand_sequencer.md
# matrix_operand_sequencer

Parametrised operand sequencer for the matrix multiplier datapath. It walks every output element C[i][j] of C = A·B in row-major order and, for each element, every inner index k. For each step it reads A[i][k] and B[k][j] from the two operand memories and dispatches the pair to one of NUM_LANES multiplier lanes. Each dispatched pair carries tags that let the downstream accumulator know element, row and job boundaries. It sits between the A/B operand RAMs and the multiplier bank. It generalises the earlier fixed 8×8, 4-multiplier fetcher to arbitrary M×K·K×N shapes, any lane count, and per-lane busy backpressure.

## Interface
Parameters:
- A_ROWS, default 8: M, number of rows of A and of C.
- INNER, default 8: K, columns of A and rows of B.
- B_COLS, default 8: N, columns of B and of C.
- DATA_WIDTH, default 32: operand width.
- NUM_LANES, default 4: L, number of multiplier lanes (≥1).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a job; ignored unless in IDLE.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse after the final pair is dispatched.
- rd_en_a / rd_en_b  out  1  read strobes; always asserted together.
- rd_addr_a  out  clog2(M·K)  address of A[i][k], equal to i·K+k (A stored row-major).
- rd_addr_b  out  clog2(K·N)  address of B[k][j], equal to k·N+j (B stored row-major).
- rd_data_a / rd_data_b  in  DATA_WIDTH  read data, valid exactly 1 cycle after the strobe.
- lane_a / lane_b  out  L·DATA_WIDTH  per-lane operands; lane n uses slice [n·W +: W].
- lane_en  out  L  one-hot dispatch pulse.
- lane_busy  in  L  per-lane busy.
- tag_first / tag_last  out  1  pair is k==0 / k==K-1 of its element.
- tag_row  out  clog2(M)  index i of the dispatched pair.
- tag_col  out  clog2(N)  index j of the dispatched pair.
- new_row  out  1  pulse with the last pair of row i (k==K-1 and j==N-1).

## Operation
- FSM states and transitions:
  - IDLE → FETCH on start.
  - FETCH → DRAIN after the issue of pair (M-1, N-1, K-1).
  - DRAIN → IDLE when no pair is in flight; done pulses on this transition.
- Iteration order: k innermost, then j, then i. Counters wrap at K-1, N-1 and M-1 respectively.
- Lane selection: the target lane is k mod L. When L does not divide K, lane assignment restarts at lane 0 for each new element.
- Issue rule: in FETCH, a pair issues (rd_en high, counters advance) only when the target lane is free. A lane is free when lane_busy[t]==0 and the lane has no pair in flight. A pair is in flight from its issue cycle through its lane_en cycle inclusive.
- Stall: when the target lane is not free, rd_en stays low and the counters and addresses hold. Issue is strictly in order; no other lane is served ahead of the stalled one.
- Dispatch: read data is registered into the lane_a/lane_b slices of the target lane. lane_en[t] pulses for 1 cycle, and the tags are valid in that same cycle. Non-target slices hold their previous values.
- Lane contract: a lane raises lane_busy no later than the cycle after its lane_en. If it does not, the lane is treated as free.
- Reset values: busy, done, rd_en_a/b, lane_en, tag_first, tag_last and new_row are 0. Addresses, tags and lane slices are 0. State is IDLE.
- Reset mid-job: abandons the job immediately. The next cycle shows reset values; in-flight pairs are dropped with no lane_en.
- start while busy: ignored, with no effect on counters.
- K==1: every pair has tag_first=tag_last=1.
- L==1: every pair goes to lane 0.

## Timing
- start accepted in cycle c:
  - busy=1 and first issue from c+1.
  - first lane_en at c+3 (1 cycle RAM latency plus 1 cycle register).
- Throughput: one pair per cycle when L≥3 and all lanes are idle. When L<3, the in-flight window limits throughput to one pair per 3 cycles per lane.
- Total pairs P = M·N·K. With no stalls and L≥3:
  - last lane_en at c+2+P;
  - done at c+3+P;
  - busy falls at c+4+P.
- Latency from issue to lane_en is fixed at 2 cycles regardless of stalls.

## Test plan
- Reset: assert rst for 2 cycles during FETCH. Required: all outputs 0 the next cycle, no lane_en afterwards, and a fresh start restarts from address 0.
- Basic run (M=2, K=3, N=2, L=4, W=8, A=1..6, B=1..6, lane_busy=0), start at c:
  - rd_addr_a sequence 0,1,2,0,1,2,3,4,5,3,4,5;
  - rd_addr_b sequence 0,2,4,1,3,5,0,2,4,1,3,5;
  - 12 lane_en pulses on lanes 0,1,2 repeating;
  - first lane_en carries (1,1), tag_first=1, row 0, col 0;
  - new_row at pairs 6 and 12;
  - done at c+15.
- Backpressure: same setup, hold lane_busy[1]=1 for 5 cycles when pair 2 is due. Required: rd_en low for exactly those cycles, address sequence unchanged, done delayed by 5.
- Single lane (L=1, M=N=1, K=4): lane_en on lane 0 exactly every 3 cycles, tag_last only on the 4th pulse.
- start during busy and K=1 (M=N=2): extra start has no effect; 4 pairs dispatched, each with tag_first=tag_last=1.
